// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: cache-line word, arbiter state encoding, starvation counter width.
package lc3b_types;
   localparam int LC3B_LINE_W  = 128;
   localparam int ARB_STARVE_W = 4;

   typedef logic [LC3B_LINE_W-1:0] lc3b_line;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RESP
   } arb_state_t;
endpackage

// File: rtl/mem_arb_perf.sv
// Arbiter performance counters: I grants, D grants, IDLE cycles with both sides requesting.
// Counts are visible the cycle after the event; each counter saturates at 16'hFFFF; no backpressure.
module mem_arb_perf (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_grant,
   input  logic        d_grant,
   input  logic        contention,
   output logic [15:0] perf_i_grants,
   output logic [15:0] perf_d_grants,
   output logic [15:0] perf_contention
);
   localparam logic [15:0] SAT = 16'hFFFF;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_i_grants   <= '0;
         perf_d_grants   <= '0;
         perf_contention <= '0;
      end else begin
         if (i_grant && perf_i_grants != SAT)
            perf_i_grants <= perf_i_grants + 16'd1;
         if (d_grant && perf_d_grants != SAT)
            perf_d_grants <= perf_d_grants + 16'd1;
         if (contention && perf_contention != SAT)
            perf_contention <= perf_contention + 16'd1;
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// I/D cache-miss arbiter onto one memory port; D priority with an I starvation guard. Optional MEM_ARB_PERF_CNT_EN adds perf counters.
// Grant to m_read/m_write in 1 cycle, m_resp to x_resp in 1 cycle; requesters hold until resp, one transaction in flight.
module mem_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_WIDTH   = 16,
   parameter int LINE_WIDTH   = 128,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic                  m_read,
   output logic                  m_write,
   output logic [ADDR_WIDTH-1:0] m_address,
   output logic [LINE_WIDTH-1:0] m_wdata,
   input  logic [LINE_WIDTH-1:0] m_rdata,
   input  logic                  m_resp
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [15:0]           perf_i_grants,
   output logic [15:0]           perf_d_grants,
   output logic [15:0]           perf_contention
`endif
);
   localparam logic [ARB_STARVE_W-1:0] STARVE_MAX = ARB_STARVE_W'(STARVE_LIMIT);

   arb_state_t              state, state_nx;
   logic                    grant_d_q, write_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [LINE_WIDTH-1:0]   wdata_q;
   logic [ARB_STARVE_W-1:0] starve_cnt;
   logic                    force_i, take_d, take_i, busy;

   always_comb begin
      state_nx = state;
      take_d   = 1'b0;
      take_i   = 1'b0;
      busy     = 1'b0;
      m_read   = 1'b0;
      m_write  = 1'b0;
      i_resp   = 1'b0;
      d_resp   = 1'b0;
      force_i  = i_read && (starve_cnt == STARVE_MAX);
      case (state)
         IDLE: begin
            take_d = (d_read || d_write) && !force_i;
            take_i = i_read && !take_d;
            if (take_d)
               state_nx = BUSY_D;
            else if (take_i)
               state_nx = BUSY_I;
         end
         BUSY_I, BUSY_D: begin
            busy    = 1'b1;
            m_read  = !write_q;
            m_write = write_q;
            if (m_resp)
               state_nx = RESP;
         end
         RESP: begin
            i_resp   = !grant_d_q;
            d_resp   = grant_d_q;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign m_address = addr_q;
   assign m_wdata   = wdata_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant_d_q  <= 1'b0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         starve_cnt <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         state <= state_nx;
         // Latch the whole request so requester changes mid-transaction are invisible to memory
         if (take_d || take_i) begin
            grant_d_q <= take_d;
            write_q   <= take_d && d_write;
            addr_q    <= take_d ? d_address : i_address;
            wdata_q   <= take_d ? d_wdata : '0;
         end
         if (take_i)
            starve_cnt <= '0;
         else if (take_d && i_read && starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + 1'b1;
         if (busy && m_resp) begin
            if (grant_d_q)
               d_rdata <= m_rdata;
            else
               i_rdata <= m_rdata;
         end
      end
   end

`ifdef MEM_ARB_PERF_CNT_EN
   mem_arb_perf u_perf (
      .clk             (clk),
      .reset_n         (reset_n),
      .i_grant         (take_i),
      .d_grant         (take_d),
      .contention      ((state == IDLE) && i_read && (d_read || d_write)),
      .perf_i_grants   (perf_i_grants),
      .perf_d_grants   (perf_d_grants),
      .perf_contention (perf_contention)
   );
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester/memory agent plus expected-grant and expected-rdata queues.
`timescale 1ns/1ps
module tb_mem_arbiter;
   import lc3b_types::*;

   typedef struct {
      logic        side_d;
      logic        wr;
      logic [15:0] addr;
      lc3b_line    wdata;
      lc3b_line    rdata;
      int          lat;
   } txn_t;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      lc3b_line    wdata;
   } dreq_t;

   logic        clk, reset_n;
   logic        i_read, i_resp, d_read, d_write, d_resp;
   logic        m_read, m_write, m_resp;
   logic [15:0] i_address, d_address, m_address;
   lc3b_line    i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
   logic [15:0] perf_i_grants, perf_d_grants, perf_contention;
   logic [15:0] sat_i, sat_d, sat_c;
   logic        sat_cont;
`endif

   mem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_resp(m_resp)
`ifdef MEM_ARB_PERF_CNT_EN
      , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
      .perf_contention(perf_contention)
`endif
   );

`ifdef MEM_ARB_PERF_CNT_EN
   mem_arb_perf u_sat (
      .clk(clk), .reset_n(reset_n), .i_grant(1'b0), .d_grant(1'b0), .contention(sat_cont),
      .perf_i_grants(sat_i), .perf_d_grants(sat_d), .perf_contention(sat_c)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;
   int cyc = 0;
   int i_resp_cnt = 0, d_resp_cnt = 0, excl_viol = 0, rd_in_write = 0;
   int last_mresp_cyc = 0, last_d_resp_cyc = 0, last_start_cyc = 0, i_assert_cyc = 0;
   bit mem_en = 1'b1, inj_resp = 1'b0, active = 1'b0;
   int mcnt = 0;
   logic prev_i = 1'b0;
   txn_t cur;
   txn_t exp_q[$];
   lc3b_line i_exp_q[$], d_exp_q[$];
   logic [15:0] i_req_q[$];
   dreq_t d_req_q[$];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic txn_t mk(input logic sd, input logic wr, input logic [15:0] a,
                               input lc3b_line wd, input lc3b_line rd, input int lat);
      txn_t t;
      t.side_d = sd; t.wr = wr; t.addr = a; t.wdata = wd; t.rdata = rd; t.lat = lat;
      return t;
   endfunction

   function automatic lc3b_line rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic push_d(input logic rd, input logic wr, input logic [15:0] a, input lc3b_line wd);
      dreq_t r;
      r.rd = rd; r.wr = wr; r.addr = a; r.wdata = wd;
      d_req_q.push_back(r);
   endtask

   // Requesters and memory model, sampled and driven 1ns after each rising edge
   initial begin
      i_read = 0; d_read = 0; d_write = 0; i_address = 0; d_address = 0;
      d_wdata = 0; m_rdata = 0; m_resp = 0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         m_resp = 1'b0;
         if (m_read && m_write) excl_viol++;
         if (active && cur.wr && m_read) rd_in_write++;
         if (i_resp) begin
            i_resp_cnt++;
            check("i_resp_lat", cyc - last_mresp_cyc, 1);
            check("i_resp_expected", i_exp_q.size() > 0, 1);
            if (i_exp_q.size() > 0) check("i_rdata", i_rdata, i_exp_q.pop_front());
            if (i_req_q.size() > 0) void'(i_req_q.pop_front());
         end
         if (d_resp) begin
            d_resp_cnt++;
            last_d_resp_cyc = cyc;
            check("d_resp_lat", cyc - last_mresp_cyc, 1);
            check("d_resp_expected", d_exp_q.size() > 0, 1);
            if (d_exp_q.size() > 0) check("d_rdata", d_rdata, d_exp_q.pop_front());
            if (d_req_q.size() > 0) void'(d_req_q.pop_front());
         end
         if (active) begin
            mcnt++;
            if (mcnt == cur.lat) begin
               check("addr_stable", m_address, cur.addr);
               if (cur.wr) check("wdata_stable", m_wdata, cur.wdata);
               m_resp = 1'b1;
               m_rdata = cur.rdata;
               last_mresp_cyc = cyc;
               active = 1'b0;
               if (cur.side_d) d_exp_q.push_back(cur.rdata);
               else            i_exp_q.push_back(cur.rdata);
            end
         end else if (mem_en && (m_read || m_write)) begin
            last_start_cyc = cyc;
            check("grant_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               cur = exp_q.pop_front();
               mcnt = 0;
               active = 1'b1;
               check("m_address", m_address, cur.addr);
               check("m_write", m_write, cur.wr);
               check("m_read", m_read, !cur.wr);
               if (cur.wr) check("m_wdata", m_wdata, cur.wdata);
            end
         end
         if (inj_resp) begin
            m_resp = 1'b1;
            m_rdata = '1;
            inj_resp = 1'b0;
         end
         i_read = (i_req_q.size() > 0);
         if (i_read) i_address = i_req_q[0];
         if (i_read && !prev_i) i_assert_cyc = cyc;
         prev_i = i_read;
         if (d_req_q.size() > 0) begin
            d_read = d_req_q[0].rd; d_write = d_req_q[0].wr;
            d_address = d_req_q[0].addr; d_wdata = d_req_q[0].wdata;
         end else begin
            d_read = 1'b0; d_write = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int k = 0;
      while ((i_req_q.size() > 0 || d_req_q.size() > 0 || exp_q.size() > 0 || active) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_drain"}, k < budget, 1);
      tick(2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      lc3b_line w, a5;
      int bi, bd, k;
      a5 = {16{8'hA5}};
      reset_n = 1'b0;
`ifdef MEM_ARB_PERF_CNT_EN
      sat_cont = 1'b0;
`endif
      tick(3);
      check("rst_m_read", m_read, 0);
      check("rst_m_write", m_write, 0);
      check("rst_m_address", m_address, 0);
      check("rst_m_wdata", m_wdata, 0);
      check("rst_i_resp", i_resp, 0);
      check("rst_d_resp", d_resp, 0);
      check("rst_i_rdata", i_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      reset_n = 1'b1;
      tick(1);

      // I only, memory latency 5
      bi = i_resp_cnt; bd = d_resp_cnt;
      exp_q.push_back(mk(1'b0, 1'b0, 16'h1230, '0, a5, 5));
      i_req_q.push_back(16'h1230);
      wait_drain(50, "ionly");
      check("ionly_grant_lat", last_start_cyc - i_assert_cyc, 1);
      check("ionly_i_resp_cycles", i_resp_cnt - bi, 1);
      check("ionly_d_resp_cycles", d_resp_cnt - bd, 0);
      tick(3);
      check("ionly_i_rdata_hold", i_rdata, a5);

      // Simultaneous I read and D write: D first, I granted in the IDLE after d_resp
      exp_q.push_back(mk(1'b1, 1'b1, 16'h4000, 128'h1, rnd(), 3));
      exp_q.push_back(mk(1'b0, 1'b0, 16'h2000, '0, rnd(), 2));
      push_d(1'b0, 1'b1, 16'h4000, 128'h1);
      i_req_q.push_back(16'h2000);
      wait_drain(60, "simul");
      check("simul_i_after_d", last_start_cyc - last_d_resp_cyc, 2);

      // Starvation guard: D,D,D,D,I,D,D
      for (int j = 0; j < 4; j++)
         exp_q.push_back(mk(1'b1, 1'b0, 16'h5000 + 16'(j * 16), '0, rnd(), 1 + j % 3));
      exp_q.push_back(mk(1'b0, 1'b0, 16'h3000, '0, rnd(), 2));
      for (int j = 4; j < 6; j++)
         exp_q.push_back(mk(1'b1, 1'b0, 16'h5000 + 16'(j * 16), '0, rnd(), 1 + j % 3));
      for (int j = 0; j < 6; j++)
         push_d(1'b1, 1'b0, 16'h5000 + 16'(j * 16), '0);
      i_req_q.push_back(16'h3000);
      wait_drain(200, "starve");

      // d_read and d_write together behave as a write
      w = rnd();
      exp_q.push_back(mk(1'b1, 1'b1, 16'h6000, w, rnd(), 4));
      push_d(1'b1, 1'b1, 16'h6000, w);
      wait_drain(60, "rdwr");
      check("rdwr_no_m_read", rd_in_write, 0);

      // Reset during BUSY_D, then a stray m_resp
      mem_en = 1'b0;
      bd = d_resp_cnt;
      push_d(1'b1, 1'b0, 16'h7000, '0);
      k = 0;
      while (!m_read && k < 20) begin
         tick(1);
         k++;
      end
      check("rst_mid_busy_reached", m_read, 1);
      reset_n = 1'b0;
      d_req_q.delete();
      tick(1);
      reset_n = 1'b1;
      inj_resp = 1'b1;
      tick(4);
      check("rst_mid_m_read", m_read, 0);
      check("rst_mid_m_write", m_write, 0);
      check("rst_mid_m_address", m_address, 0);
      check("rst_mid_m_wdata", m_wdata, 0);
      check("rst_mid_d_rdata", d_rdata, 0);
      check("rst_mid_i_rdata", i_rdata, 0);
      check("rst_mid_no_d_resp", d_resp_cnt - bd, 0);
      check("rst_mid_state", dut.state, IDLE);
      mem_en = 1'b1;

`ifdef MEM_ARB_PERF_CNT_EN
      exp_q.push_back(mk(1'b1, 1'b0, 16'h8000, '0, rnd(), 2));
      exp_q.push_back(mk(1'b0, 1'b0, 16'h8100, '0, rnd(), 2));
      push_d(1'b1, 1'b0, 16'h8000, '0);
      i_req_q.push_back(16'h8100);
      wait_drain(60, "perf_a");
      exp_q.push_back(mk(1'b0, 1'b0, 16'h8200, '0, rnd(), 1));
      i_req_q.push_back(16'h8200);
      wait_drain(60, "perf_b");
      exp_q.push_back(mk(1'b0, 1'b0, 16'h8300, '0, rnd(), 1));
      i_req_q.push_back(16'h8300);
      wait_drain(60, "perf_c");
      exp_q.push_back(mk(1'b1, 1'b1, 16'h8400, 128'h5, rnd(), 1));
      push_d(1'b0, 1'b1, 16'h8400, 128'h5);
      wait_drain(60, "perf_d");
      check("perf_i_grants", perf_i_grants, 3);
      check("perf_d_grants", perf_d_grants, 2);
      check("perf_contention", perf_contention, 1);
      sat_cont = 1'b1;
      tick(65600);
      sat_cont = 1'b0;
      tick(2);
      check("perf_contention_sat", sat_c, 16'hFFFF);
      check("perf_sat_i_idle", sat_i, 0);
`endif

      // Normal service after the mid-transaction reset
      exp_q.push_back(mk(1'b0, 1'b0, 16'h1240, '0, rnd(), 3));
      i_req_q.push_back(16'h1240);
      wait_drain(60, "post_rst");
      check("rw_never_both", excl_viol, 0);
      check("resp_queues_empty", i_exp_q.size() + d_exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
